// File: rtl/mdio_arbiter_if.sv
// Bus between the MDIO arbiter, its requesters and the shared MDIO serializer.
// M_RDATA carries the 16-bit read result from the serializer. It is valid while M_DATA_RDY is high.
interface mdio_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    // Requester side
    logic [NUM_REQ-1:0]    REQ;
    logic [NUM_REQ-1:0]    REQ_WR;
    logic [5*NUM_REQ-1:0]  REQ_PHY;
    logic [5*NUM_REQ-1:0]  REQ_REG;
    logic [16*NUM_REQ-1:0] REQ_WDATA;
    logic [NUM_REQ-1:0]    GNT;
    logic [NUM_REQ-1:0]    DONE;
    logic [15:0]           RDATA;
    logic                  ERR;
    // Serializer side
    logic                  M_RUN;
    logic                  M_START;
    logic [31:0]           M_T_DATA;
    logic                  M_DATA_RDY;
    logic [15:0]           M_RDATA;

    // The arbiter serves requests and drives the serializer.
    modport slave (
        input  REQ, REQ_WR, REQ_PHY, REQ_REG, REQ_WDATA, M_DATA_RDY, M_RDATA,
        output GNT, DONE, RDATA, ERR, M_RUN, M_START, M_T_DATA
    );

    // Requesters and the serializer model, seen from outside the arbiter.
    modport master (
        output REQ, REQ_WR, REQ_PHY, REQ_REG, REQ_WDATA, M_DATA_RDY, M_RDATA,
        input  GNT, DONE, RDATA, ERR, M_RUN, M_START, M_T_DATA
    );
endinterface

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter that shares one MDIO serializer between NUM_REQ requesters.
// It builds the clause-22 frame, starts the serializer and waits for the frame to complete.
// It then returns the read data, or 16'hFFFF with ERR set if the read times out.
module mdio_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WR_CYCLES = 64,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          RESET,
    mdio_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StFin} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               wr_q, wr_d;
    logic [31:0]        frame_q, frame_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic               sel_wr;
    logic [4:0]         sel_phy;
    logic [4:0]         sel_reg;
    logic [15:0]        sel_wdata;

    // Winner search from the pointer upward with wrap, then mux out the winner's fields.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        sel_wr    = 1'b0;
        sel_phy   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                sel_wr    = bus.REQ_WR[i];
                sel_phy   = bus.REQ_PHY[5*i +: 5];
                sel_reg   = bus.REQ_REG[5*i +: 5];
                sel_wdata = bus.REQ_WDATA[16*i +: 16];
            end
        end
    end

    // Next-state logic: grant, start pulse, completion/timeout tracking, release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        frame_d = frame_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    wr_d    = sel_wr;
                    frame_d = {2'b01, (sel_wr ? 2'b01 : 2'b10), sel_phy, sel_reg, 2'b10,
                               (sel_wr ? sel_wdata : 16'h0000)};
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (wr_q) begin
                    // Writes complete on a fixed cycle count; the ready flag is not meaningful.
                    if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
                        err_d   = 1'b0;
                        state_d = StFin;
                    end
                end else if (bus.M_DATA_RDY) begin
                    // Ready wins over a timeout on the same cycle.
                    rdata_d = bus.M_RDATA;
                    err_d   = 1'b0;
                    state_d = StFin;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = 16'hFFFF;
                    err_d   = 1'b1;
                    state_d = StFin;
                end
            end
            StFin: begin
                gnt_d   = '0;
                ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; RESET aborts any frame in flight.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            frame_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            frame_q <= frame_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them without a clock.
    assign bus.GNT      = gnt_q;
    assign bus.DONE     = (state_q == StFin) ? gnt_q : '0;
    assign bus.RDATA    = rdata_q;
    assign bus.ERR      = err_q;
    assign bus.M_RUN    = (state_q == StStart) || (state_q == StWait);
    assign bus.M_START  = (state_q == StStart);
    assign bus.M_T_DATA = frame_q;
endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter. Stimulus queues the expected transactions.
// A negedge monitor checks each start pulse and each DONE pulse against the head of the queue.
module tb_mdio_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 255;

    typedef struct {
        logic [N-1:0] gnt;
        logic [31:0]  frame;
        logic [15:0]  rdata;
        logic         err;
        logic         chk_rd;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    int   resp_cnt = -1;
    logic [15:0] resp_data = 16'h0000;
    exp_t start_q[$];
    exp_t done_q[$];

    mdio_arbiter_if #(.NUM_REQ(N)) bus ();

    mdio_arbiter #(.NUM_REQ(N), .WR_CYCLES(64), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd);
        bus.REQ_WR[i]            = wr;
        bus.REQ_PHY[5*i +: 5]    = phy;
        bus.REQ_REG[5*i +: 5]    = rg;
        bus.REQ_WDATA[16*i +: 16] = wd;
    endtask

    task automatic expect_txn(input int i, input logic [31:0] frame, input logic [15:0] rd,
                              input bit err, input bit chk_rd, input int lat,
                              input bit completes);
        exp_t e;
        e.gnt    = N'(1) << i;
        e.frame  = frame;
        e.rdata  = rd;
        e.err    = err;
        e.chk_rd = chk_rd;
        e.lat    = lat;
        start_q.push_back(e);
        if (completes) done_q.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL wait_done: got %0d DONE pulses expected %0d", done_cnt, target);
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (start_cnt < target) begin
            errors++;
            $display("FAIL wait_starts: got %0d starts expected %0d", start_cnt, target);
        end
    endtask

    // Serializer model: pulses M_DATA_RDY so the arbiter sees it at WAIT count resp_cnt.
    initial begin
        int k;
        k = 100000;
        bus.M_DATA_RDY = 1'b0;
        bus.M_RDATA    = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.M_START) k = 0;
            else if (k < 100000) k++;
            if (resp_cnt >= 0 && k == resp_cnt + 1) begin
                bus.M_DATA_RDY = 1'b1;
                bus.M_RDATA    = resp_data;
            end else begin
                bus.M_DATA_RDY = 1'b0;
                bus.M_RDATA    = 16'hDEAD;
            end
        end
    end

    // Monitor: checks start pulses, DONE pulses, M_RUN gaps and DONE pulse width.
    initial begin
        exp_t         e;
        logic [N-1:0] prev_done;
        logic         prev_run;
        int           low;
        prev_done = '0;
        prev_run  = 1'b0;
        low       = 0;
        forever begin
            @(negedge clk);
            if (bus.M_RUN && !prev_run) chk("run_low_gap_ge2", 32'(low >= 2), 32'd1);
            if (bus.M_START) begin
                start_cnt++;
                if (start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got GNT %b expected no start", bus.GNT);
                end else begin
                    e = start_q.pop_front();
                    chk("start_gnt", 32'(bus.GNT), 32'(e.gnt));
                    chk("start_frame", bus.M_T_DATA, e.frame);
                    start_cyc = cyc;
                end
            end
            if (bus.DONE != '0) begin
                done_cnt++;
                chk("done_one_clk", 32'(prev_done), 32'd0);
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE %b expected none", bus.DONE);
                end else begin
                    e = done_q.pop_front();
                    chk("done_owner", 32'(bus.DONE), 32'(e.gnt));
                    chk("done_err", 32'(bus.ERR), 32'(e.err));
                    chk("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
                    chk("done_frame_stable", bus.M_T_DATA, e.frame);
                    chk("done_run_low", 32'(bus.M_RUN), 32'd0);
                    if (e.chk_rd) chk("done_rdata", 32'(bus.RDATA), 32'(e.rdata));
                end
            end
            if (!bus.M_RUN) low++;
            else low = 0;
            prev_done = bus.DONE;
            prev_run  = bus.M_RUN;
        end
    end

    initial begin
        RESET         = 1'b1;
        bus.REQ       = '0;
        bus.REQ_WR    = '0;
        bus.REQ_PHY   = '0;
        bus.REQ_REG   = '0;
        bus.REQ_WDATA = '0;
        // Frames: {01, op, phy, reg, 10, data}
        set_req(0, 1'b1, 5'h01, 5'h02, 16'hBEEF);   // 32'h508ABEEF
        set_req(1, 1'b1, 5'h03, 5'h04, 16'h1111);   // 32'h51921111
        set_req(2, 1'b0, 5'h1F, 5'h00, 16'hCAFE);   // 32'h6F820000 (read, data field 0)
        set_req(3, 1'b1, 5'h10, 5'h1F, 16'hA5A5);   // 32'h587EA5A5
        repeat (2) tick();
        chk("rst_gnt", 32'(bus.GNT), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_run", 32'(bus.M_RUN), 32'd0);
        chk("rst_start", 32'(bus.M_START), 32'd0);
        chk("rst_tdata", bus.M_T_DATA, 32'd0);
        chk("rst_rdata", 32'(bus.RDATA), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);
        RESET = 1'b0;
        tick();

        // Fairness: all four held, pointer at 0 -> 0,1,2,3,0. Writes ignore the ready pulse.
        resp_cnt  = 5;
        resp_data = 16'h5A5A;
        expect_txn(0, 32'h508ABEEF, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        expect_txn(1, 32'h51921111, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        expect_txn(2, 32'h6F820000, 16'h5A5A, 1'b0, 1'b1, 7, 1'b1);
        expect_txn(3, 32'h587EA5A5, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        expect_txn(0, 32'h508ABEEF, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        bus.REQ = 4'b1111;
        wait_starts(5, 800);
        bus.REQ = '0;
        wait_done(5, 300);

        // Single write; a stray ready pulse at count 10 must not end it early.
        resp_cnt = 10;
        expect_txn(0, 32'h508ABEEF, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        bus.REQ = 4'b0001;
        tick();
        bus.REQ = '0;
        wait_done(6, 200);

        // Read answered at WAIT count 40.
        resp_cnt  = 40;
        resp_data = 16'h1234;
        expect_txn(2, 32'h6F820000, 16'h1234, 1'b0, 1'b1, 42, 1'b1);
        bus.REQ = 4'b0100;
        tick();
        bus.REQ = '0;
        wait_done(7, 200);

        // Read that never gets ready: times out after TMO WAIT cycles.
        resp_cnt = -1;
        expect_txn(2, 32'h6F820000, 16'hFFFF, 1'b1, 1'b1, TMO + 1, 1'b1);
        bus.REQ = 4'b0100;
        tick();
        bus.REQ = '0;
        wait_done(8, 400);

        // Write with REQ dropped 3 clks after grant; it also clears the timeout ERR.
        expect_txn(1, 32'h51921111, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        bus.REQ = 4'b0010;
        tick();
        repeat (3) tick();
        bus.REQ = '0;
        wait_done(9, 200);

        // Async reset in the middle of a read's WAIT: no DONE, outputs clear without an edge.
        expect_txn(2, 32'h6F820000, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        bus.REQ = 4'b0100;
        tick();
        bus.REQ = '0;
        repeat (20) tick();
        #1 RESET = 1'b1;
        #1;
        chk("arst_gnt", 32'(bus.GNT), 32'd0);
        chk("arst_run", 32'(bus.M_RUN), 32'd0);
        chk("arst_start", 32'(bus.M_START), 32'd0);
        chk("arst_tdata", bus.M_T_DATA, 32'd0);
        chk("arst_done", 32'(bus.DONE), 32'd0);
        chk("arst_err", 32'(bus.ERR), 32'd0);
        repeat (2) tick();
        RESET = 1'b0;
        tick();

        // Pointer was 2 before reset (3 would win); after reset it is 0, so 0 wins.
        expect_txn(0, 32'h508ABEEF, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        expect_txn(3, 32'h587EA5A5, 16'h0000, 1'b0, 1'b0, 65, 1'b1);
        bus.REQ = 4'b1001;
        wait_starts(start_cnt + 2, 300);
        bus.REQ = '0;
        wait_done(11, 200);

        repeat (5) tick();
        chk("start_queue_drained", 32'(start_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        chk("total_done_pulses", 32'(done_cnt), 32'd11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
